// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: detects the start edge, times each bit, drives the
// deserializer enable and checks start glitch, parity and stop bit.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic       sampled_bit,
  input  logic [5:0] prescale,
  input  logic       par_en,
  input  logic       par_typ,
  output logic       deser_en,
  output logic [5:0] edge_count,
  output logic       busy,
  output logic       data_valid,
  output logic       par_err,
  output logic       stp_err
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic [5:0]    edge_q, edge_d;
  logic [5:0]    presc_q, presc_d;
  logic [5:0]    presc_clamped;
  logic [BW-1:0] bit_q, bit_d;
  logic          acc_q, acc_d;
  logic          par_err_q, par_err_d;
  logic          stp_err_q, stp_err_d;
  logic          dv_q, dv_d;
  logic          end_of_bit;

  // Out-of-range prescale values are pulled into the range the sampler can handle.
  assign presc_clamped = (prescale < 6'd4)  ? 6'd4  :
                         (prescale > 6'd32) ? 6'd32 : prescale;
  assign end_of_bit    = (edge_q == presc_q - 6'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      edge_q    <= 6'd0;
      presc_q   <= 6'd8;
      bit_q     <= '0;
      acc_q     <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
      dv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      edge_q    <= edge_d;
      presc_q   <= presc_d;
      bit_q     <= bit_d;
      acc_q     <= acc_d;
      par_err_q <= par_err_d;
      stp_err_q <= stp_err_d;
      dv_q      <= dv_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    edge_d    = 6'd0;
    presc_d   = presc_q;
    bit_d     = bit_q;
    acc_d     = acc_q;
    par_err_d = par_err_q;
    stp_err_d = stp_err_q;
    dv_d      = 1'b0;

    if (state_q != IDLE) begin
      edge_d = end_of_bit ? 6'd0 : edge_q + 6'd1;
    end

    case (state_q)
      IDLE: begin
        if (!rx_in) begin
          state_d   = START;
          presc_d   = presc_clamped;
          par_err_d = 1'b0;
          stp_err_d = 1'b0;
          acc_d     = 1'b0;
        end
      end
      START: begin
        if (end_of_bit) begin
          if (sampled_bit) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            bit_d   = '0;
          end
        end
      end
      DATA: begin
        if (end_of_bit) begin
          acc_d = acc_q ^ sampled_bit;
          bit_d = bit_q + 1'b1;
          if (bit_q == LAST_BIT) begin
            state_d = par_en ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (end_of_bit) begin
          par_err_d = sampled_bit ^ acc_q ^ par_typ;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (end_of_bit) begin
          stp_err_d = ~sampled_bit;
          // The word is only good if both the new stop result and parity are clean.
          dv_d      = sampled_bit & ~par_err_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign deser_en   = (state_q == DATA);
  assign busy       = (state_q != IDLE);
  assign edge_count = edge_q;
  assign data_valid = dv_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;

endmodule
